// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack primitive.
// Holds up to DEPTH words of WIDTH bits. Push and pop may be requested in the
// same cycle: with data present the top entry is replaced and the old top is
// returned, and on an empty stack the input word passes straight to dataOut.
// Pop data is registered (one-cycle latency) and qualified by a one-cycle
// dataOutValid pulse. Top is a combinational peek of the current top entry.
// OVF/UDF are sticky error flags that ClrErr clears; a new error in the same
// cycle as ClrErr takes priority over the clear.
module lifo_stack_param #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              EN,
  input  logic              Push,
  input  logic              Pop,
  input  logic [WIDTH-1:0]  dataIn,
  input  logic              ClrErr,
  output logic [WIDTH-1:0]  dataOut,
  output logic              dataOutValid,
  output logic [WIDTH-1:0]  Top,
  output logic [CW-1:0]     Count,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ALMOST_FULL,
  output logic              OVF,
  output logic              UDF
);

  // Storage index width; DEPTH >= 2 so this is at least one bit.
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Occupancy thresholds sized to the count register.
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  // Storage array (no reset: contents are meaningless while Count is zero).
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Control / output registers and their next-state values.
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic             dvld_q,  dvld_d;
  logic             ovf_q,   ovf_d;
  logic             udf_q,   udf_d;

  // Storage write port.
  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  // Occupancy decode and top-of-stack index.
  logic             empty_w;
  logic             full_w;
  logic [IW-1:0]    top_idx;
  logic             ovf_set;
  logic             udf_set;

  // Decode occupancy; the top index is clamped to 0 when empty so the peek
  // never addresses a slot outside the array.
  always_comb begin
    empty_w = (count_q == '0);
    full_w  = (count_q == DEPTH_C);
    top_idx = empty_w ? '0 : IW'(count_q - 1'b1);
  end

  // Next-state decode for one enabled cycle: push, pop or top replacement.
  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    dvld_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = top_idx;
    wr_data = dataIn;
    ovf_set = 1'b0;
    udf_set = 1'b0;

    if (EN) begin
      case ({Push, Pop})
        2'b10: begin
          // Push only: rejected (and flagged) when full, so Count never wraps.
          if (!full_w) begin
            wr_en   = 1'b1;
            wr_idx  = IW'(count_q);
            count_d = count_q + 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end
        2'b01: begin
          // Pop only: rejected (and flagged) when empty; dataOut holds.
          if (!empty_w) begin
            dout_d  = mem_q[top_idx];
            dvld_d  = 1'b1;
            count_d = count_q - 1'b1;
          end else begin
            udf_set = 1'b1;
          end
        end
        2'b11: begin
          // Push+pop: replace the top in place, or pass through when empty.
          // Occupancy is unchanged, so this is never an error even when full.
          dvld_d = 1'b1;
          if (!empty_w) begin
            dout_d = mem_q[top_idx];
            wr_en  = 1'b1;
            wr_idx = top_idx;
          end else begin
            dout_d = dataIn;
          end
        end
        default: begin
        end
      endcase
    end

    // Sticky flags: a fresh error outranks a clear in the same cycle.
    ovf_d = (ovf_q & ~(EN & ClrErr)) | ovf_set;
    udf_d = (udf_q & ~(EN & ClrErr)) | udf_set;
  end

  // Control and pop-data registers; asynchronous reset returns to empty.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_q <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage write; the enable already folds in EN and legality of the push.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  // Output drive: flags and peek come straight from the registered count.
  always_comb begin
    dataOut      = dout_q;
    dataOutValid = dvld_q;
    Count        = count_q;
    EMPTY        = empty_w;
    FULL         = full_w;
    ALMOST_FULL  = (count_q >= AF_C);
    OVF          = ovf_q;
    UDF          = udf_q;
    Top          = empty_w ? '0 : mem_q[top_idx];
  end

endmodule

// File: tb/tb_lifo_stack_param.sv
// Testbench for lifo_stack_param: two instances (4x4 and 8-bit x 5, AF=2)
// share one stimulus stream and are compared every cycle against a simple
// array-based stack model.
module tb_lifo_stack_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en, push, pop, clr;
  logic [7:0] din;

  // Instance A: WIDTH=4, DEPTH=4, AF_LEVEL=3 (defaults)
  logic [3:0] a_dout, a_top;
  logic [2:0] a_cnt;
  logic       a_vld, a_empty, a_full, a_af, a_ovf, a_udf;

  // Instance B: WIDTH=8, DEPTH=5, AF_LEVEL=2
  logic [7:0] b_dout, b_top;
  logic [2:0] b_cnt;
  logic       b_vld, b_empty, b_full, b_af, b_ovf, b_udf;

  lifo_stack_param u_a (
    .Clk(clk), .Rst_n(rst_n), .EN(en), .Push(push), .Pop(pop),
    .dataIn(din[3:0]), .ClrErr(clr),
    .dataOut(a_dout), .dataOutValid(a_vld), .Top(a_top), .Count(a_cnt),
    .EMPTY(a_empty), .FULL(a_full), .ALMOST_FULL(a_af), .OVF(a_ovf), .UDF(a_udf)
  );

  lifo_stack_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(2)) u_b (
    .Clk(clk), .Rst_n(rst_n), .EN(en), .Push(push), .Pop(pop),
    .dataIn(din), .ClrErr(clr),
    .dataOut(b_dout), .dataOutValid(b_vld), .Top(b_top), .Count(b_cnt),
    .EMPTY(b_empty), .FULL(b_full), .ALMOST_FULL(b_af), .OVF(b_ovf), .UDF(b_udf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one stack per instance
  int         depth [2] = '{4, 5};
  int         aflv  [2] = '{3, 2};
  logic [7:0] msk   [2] = '{8'h0F, 8'hFF};
  logic [7:0] stk   [2][8];
  int         cnt   [2];
  logic [7:0] m_dout[2];
  logic       m_vld [2];
  logic       m_ovf [2];
  logic       m_udf [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k]    = 0;
      m_dout[k] = 8'h00;
      m_vld[k]  = 1'b0;
      m_ovf[k]  = 1'b0;
      m_udf[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    logic [7:0] d;
    logic os, us;
    d  = din & msk[k];
    os = 1'b0;
    us = 1'b0;
    m_vld[k] = 1'b0;
    if (en) begin
      if (push && pop) begin
        if (cnt[k] > 0) begin
          m_dout[k] = stk[k][cnt[k]-1];
          stk[k][cnt[k]-1] = d;
        end else begin
          m_dout[k] = d;
        end
        m_vld[k] = 1'b1;
      end else if (push) begin
        if (cnt[k] < depth[k]) begin
          stk[k][cnt[k]] = d;
          cnt[k]++;
        end else os = 1'b1;
      end else if (pop) begin
        if (cnt[k] > 0) begin
          cnt[k]--;
          m_dout[k] = stk[k][cnt[k]];
          m_vld[k]  = 1'b1;
        end else us = 1'b1;
      end
      m_ovf[k] = (m_ovf[k] && !clr) || os;
      m_udf[k] = (m_udf[k] && !clr) || us;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] o_cnt, o_dout, o_top, o_vld, o_e, o_f, o_af, o_ovf, o_udf;
      logic [31:0] e_top;
      string p;
      if (k == 0) begin
        p = "A"; o_cnt = a_cnt; o_dout = a_dout; o_top = a_top; o_vld = a_vld;
        o_e = a_empty; o_f = a_full; o_af = a_af; o_ovf = a_ovf; o_udf = a_udf;
      end else begin
        p = "B"; o_cnt = b_cnt; o_dout = b_dout; o_top = b_top; o_vld = b_vld;
        o_e = b_empty; o_f = b_full; o_af = b_af; o_ovf = b_ovf; o_udf = b_udf;
      end
      e_top = (cnt[k] > 0) ? 32'(stk[k][cnt[k]-1]) : 32'd0;
      chk($sformatf("%s Count", p),        o_cnt,  32'(cnt[k]));
      chk($sformatf("%s EMPTY", p),        o_e,    32'(cnt[k] == 0));
      chk($sformatf("%s FULL", p),         o_f,    32'(cnt[k] == depth[k]));
      chk($sformatf("%s ALMOST_FULL", p),  o_af,   32'(cnt[k] >= aflv[k]));
      chk($sformatf("%s Top", p),          o_top,  e_top);
      chk($sformatf("%s dataOut", p),      o_dout, 32'(m_dout[k]));
      chk($sformatf("%s dataOutValid", p), o_vld,  32'(m_vld[k]));
      chk($sformatf("%s OVF", p),          o_ovf,  32'(m_ovf[k]));
      chk($sformatf("%s UDF", p),          o_udf,  32'(m_udf[k]));
    end
  endtask

  // One clock: drive after the falling edge, check at the next falling edge
  task automatic cyc(input logic e, input logic p, input logic q,
                     input logic c, input logic [7:0] d);
    en = e; push = p; pop = q; clr = c; din = d;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  // Reset between edges and check outputs before any clock edge occurs
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; din = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Fill: A overflows on the 5th push, B on the 6th
    cyc(1, 1, 0, 0, 8'd1);
    cyc(1, 1, 0, 0, 8'd2);
    chk("B AF at Count=2", 32'(b_af), 32'd1);
    chk("A AF at Count=2", 32'(a_af), 32'd0);
    cyc(1, 1, 0, 0, 8'd3);
    chk("A AF at Count=3", 32'(a_af), 32'd1);
    cyc(1, 1, 0, 0, 8'd4);
    chk("A FULL after 4", 32'(a_full), 32'd1);
    chk("A Top after 4", 32'(a_top), 32'd4);
    cyc(1, 1, 0, 0, 8'd5);
    chk("A OVF on full push", 32'(a_ovf), 32'd1);
    chk("A Count held at 4", 32'(a_cnt), 32'd4);
    chk("B FULL after 5", 32'(b_full), 32'd1);
    cyc(1, 1, 0, 0, 8'd6);
    chk("B OVF on full push", 32'(b_ovf), 32'd1);
    // Drain in LIFO order, ending in underflow on A
    cyc(1, 0, 1, 0, 8'd0);
    chk("A first pop", 32'(a_dout), 32'd4);
    chk("B first pop", 32'(b_dout), 32'd5);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 8'd0);
    chk("A UDF after empty pop", 32'(a_udf), 32'd1);
    cyc(1, 0, 1, 0, 8'd0);
    cyc(1, 0, 0, 1, 8'd0);
    chk("B UDF cleared", 32'(b_udf), 32'd0);
    cyc(1, 0, 1, 1, 8'd0);
    chk("B UDF set wins over clear", 32'(b_udf), 32'd1);
    cyc(1, 0, 0, 1, 8'd0);
    // Top replacement and empty pass-through
    cyc(1, 1, 0, 0, 8'h0A);
    cyc(1, 1, 0, 0, 8'h0B);
    cyc(1, 1, 1, 0, 8'h0C);
    chk("A replace dataOut", 32'(a_dout), 32'hB);
    chk("A replace Top", 32'(a_top), 32'hC);
    cyc(1, 0, 1, 0, 8'd0);
    cyc(1, 0, 1, 0, 8'd0);
    cyc(1, 1, 1, 0, 8'd7);
    chk("B pass-through", 32'(b_dout), 32'd7);
    // Disabled cycles ignore all requests
    cyc(1, 1, 0, 0, 8'h31);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 8'h55);
    // Asynchronous reset with Count=3
    cyc(1, 1, 0, 0, 8'h32);
    cyc(1, 1, 0, 0, 8'h33);
    async_reset();

    // Randomised traffic with phases biased toward push or pop
    for (int i = 0; i < 800; i++) begin
      logic e, p, q, c;
      e = ($urandom_range(0, 9) != 0);
      if ((i / 50) % 2 == 0) begin
        p = ($urandom_range(0, 3) != 0);
        q = ($urandom_range(0, 3) == 0);
      end else begin
        p = ($urandom_range(0, 3) == 0);
        q = ($urandom_range(0, 3) != 0);
      end
      c = ($urandom_range(0, 15) == 0);
      cyc(e, p, q, c, 8'($urandom));
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
